// File: rtl/path_dumper_if.sv
// path_dumper_if: start/stack/downstream handshake bundle for path_dumper.
interface path_dumper_if #(parameter int LOC_W = 8, parameter int DEPTH = 256);
  logic start;
  logic stk_empty;
  logic stk_pop;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  logic ovf;
  logic [LOC_W-1:0] stk_loc;
  logic [LOC_W-1:0] out_loc;
  logic [$clog2(DEPTH):0] path_len;
  modport master(output start, stk_loc, stk_empty, out_ready,
                 input stk_pop, out_loc, out_valid, busy, done, path_len, ovf);
  modport slave(input start, stk_loc, stk_empty, out_ready,
                output stk_pop, out_loc, out_valid, busy, done, path_len, ovf);
endinterface

// File: rtl/path_dumper.sv
// path_dumper: drains the location stack into a buffer, then replays it start-first downstream.
module path_dumper #(
  parameter int LOC_W = 8,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic rst,
  path_dumper_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, POP, CAPT, EMIT, FIN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rdIdx;
  logic [LOC_W-1:0] pathBuf [DEPTH];
  logic lastCapt;
  assign lastCapt = bus.stk_empty || (cnt + 1'b1 == CW'(DEPTH));
  always_ff @(posedge clk)
    if (state == CAPT) pathBuf[cnt[AW-1:0]] <= bus.stk_loc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdIdx <= '0;
      bus.stk_pop <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_loc <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.path_len <= '0;
      bus.ovf <= 1'b0;
    end else begin
      bus.stk_pop <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          cnt <= '0;
          bus.ovf <= 1'b0;
          bus.path_len <= '0;
          bus.busy <= 1'b1;
          bus.stk_pop <= !bus.stk_empty;
          bus.done <= bus.stk_empty;
          state <= bus.stk_empty ? FIN : POP;
        end
        POP: state <= CAPT;
        CAPT: begin
          cnt <= cnt + 1'b1;
          if (lastCapt) begin
            // the newest entry is still in flight to pathBuf, so present it straight from the stack
            state <= EMIT;
            bus.ovf <= !bus.stk_empty;
            bus.path_len <= cnt + 1'b1;
            rdIdx <= cnt;
            bus.out_valid <= 1'b1;
            bus.out_loc <= bus.stk_loc;
          end else begin
            state <= POP;
            bus.stk_pop <= 1'b1;
          end
        end
        EMIT: if (bus.out_ready) begin
          if (rdIdx == '0) begin
            state <= FIN;
            bus.out_valid <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            rdIdx <= rdIdx - 1'b1;
            bus.out_loc <= pathBuf[AW'(rdIdx - 1'b1)];
          end
        end
        FIN: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_path_dumper.sv
// tb_path_dumper: directed stimulus with a scoreboard of expected out_loc values and a negedge monitor.
module tb_path_dumper;
  localparam int LOC_W = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  path_dumper_if #(.LOC_W(LOC_W), .DEPTH(DEPTH)) bus ();
  path_dumper #(.LOC_W(LOC_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] stkMem [16];
  logic [7:0] loadMem [16];
  int sp = 0;
  int loadN = 0;
  bit loadReq = 1'b0;
  assign bus.stk_empty = (sp == 0);
  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 16; i++) stkMem[i] <= loadMem[i];
      sp <= loadN;
    end else if (bus.stk_pop && sp > 0) begin
      bus.stk_loc <= stkMem[sp-1];
      sp <= sp - 1;
    end
  end

  logic [7:0] expq [$];
  int checks = 0;
  int errors = 0;
  int popCnt = 0;
  int doneCnt = 0;
  int xferCnt = 0;
  int validCnt = 0;
  logic prevValid = 1'b0;
  logic prevReady = 1'b0;
  logic prevPop = 1'b0;
  logic [7:0] prevLoc = 8'h0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevPop = 1'b0;
    end else begin
      if (bus.stk_pop) begin
        popCnt++;
        chk("pop_back_to_back", 32'(prevPop), 32'd0);
        chk("pop_on_empty", 32'(bus.stk_empty), 32'd0);
      end
      if (bus.done) doneCnt++;
      if (bus.out_valid) validCnt++;
      if (bus.out_valid && prevValid && !prevReady) chk("stall_stable", 32'(bus.out_loc), 32'(prevLoc));
      if (bus.out_valid && bus.out_ready) begin
        xferCnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_xfer: got %0h expected no transfer", bus.out_loc);
        end else chk("out_loc", 32'(bus.out_loc), 32'(expq.pop_front()));
      end
      prevValid = bus.out_valid;
      prevReady = bus.out_ready;
      prevLoc = bus.out_loc;
      prevPop = bus.stk_pop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic loadStack(input int n, input logic [47:0] v);
    for (int i = 0; i < n; i++) loadMem[i] = v[8*i+:8];
    loadN = n;
    loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
  endtask

  task automatic expPush(input int n, input logic [47:0] v);
    for (int i = 0; i < n; i++) expq.push_back(v[8*i+:8]);
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int base, input string nm, input bit toggle, output int cyc);
    int n = 0;
    while (doneCnt == base && n < 100) begin
      if (toggle) bus.out_ready = pat[n%4];
      tick();
      n++;
    end
    cyc = n;
    checks++;
    if (doneCnt == base) begin
      errors++;
      $display("FAIL %s: got no done pulse expected one within 100 cycles", nm);
    end
    bus.out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic waitValid(input string nm);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  int d0, p0, x0, v0, cyc;

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_stk_pop", 32'(bus.stk_pop), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_loc", 32'(bus.out_loc), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_path_len", 32'(bus.path_len), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);

    // basic drain and emit, start right after reset release
    loadStack(4, 48'h0000_1211_0100);
    expPush(4, 48'h0000_1211_0100);
    bus.out_ready = 1'b1;
    d0 = doneCnt; p0 = popCnt; x0 = xferCnt; v0 = validCnt;
    rst = 1'b0;
    pulseStart();
    chk("first_start_pop", 32'(bus.stk_pop), 32'd1);
    chk("first_start_busy", 32'(bus.busy), 32'd1);
    waitDone(d0, "t1_done", 1'b0, cyc);
    chk("t1_cycles_to_done", cyc, 13);
    chk("t1_pops", popCnt - p0, 4);
    chk("t1_xfers", xferCnt - x0, 4);
    chk("t1_valid_cycles", validCnt - v0, 4);
    chk("t1_dones", doneCnt - d0, 1);
    chk("t1_path_len", 32'(bus.path_len), 32'd4);
    chk("t1_ovf", 32'(bus.ovf), 32'd0);
    chk("t1_exp_left", expq.size(), 0);

    // stalling downstream
    loadStack(4, 48'h0000_1211_0100);
    expPush(4, 48'h0000_1211_0100);
    d0 = doneCnt; p0 = popCnt; x0 = xferCnt;
    pulseStart();
    waitDone(d0, "t2_done", 1'b1, cyc);
    chk("t2_pops", popCnt - p0, 4);
    chk("t2_xfers", xferCnt - x0, 4);
    chk("t2_dones", doneCnt - d0, 1);
    chk("t2_path_len", 32'(bus.path_len), 32'd4);
    chk("t2_exp_left", expq.size(), 0);

    // empty stack
    loadStack(0, 48'h0);
    d0 = doneCnt; p0 = popCnt; v0 = validCnt;
    pulseStart();
    waitDone(d0, "t3_done", 1'b0, cyc);
    chk("t3_pops", popCnt - p0, 0);
    chk("t3_valid_cycles", validCnt - v0, 0);
    chk("t3_dones", doneCnt - d0, 1);
    chk("t3_path_len", 32'(bus.path_len), 32'd0);
    chk("t3_busy", 32'(bus.busy), 32'd0);

    // overflow: six entries into a four-deep buffer
    loadStack(6, 48'h2524_2322_2120);
    expPush(4, 48'h0000_2524_2322);
    d0 = doneCnt; p0 = popCnt; x0 = xferCnt;
    pulseStart();
    waitDone(d0, "t4_done", 1'b0, cyc);
    chk("t4_pops", popCnt - p0, 4);
    chk("t4_xfers", xferCnt - x0, 4);
    chk("t4_ovf", 32'(bus.ovf), 32'd1);
    chk("t4_path_len", 32'(bus.path_len), 32'd4);
    chk("t4_stack_left", sp, 2);
    chk("t4_exp_left", expq.size(), 0);

    // reset after two of four transfers, then drain what remains
    loadStack(6, 48'h5554_5352_5150);
    expPush(2, 48'h0000_0000_5352);
    bus.out_ready = 1'b0;
    x0 = xferCnt;
    pulseStart();
    waitValid("t5_valid_seen");
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("t5_xfers_before_rst", xferCnt - x0, 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_stk_pop", 32'(bus.stk_pop), 32'd0);
    tick();
    rst = 1'b0;
    chk("t5_exp_left", expq.size(), 0);
    expPush(2, 48'h0000_0000_5150);
    bus.out_ready = 1'b1;
    d0 = doneCnt; p0 = popCnt; x0 = xferCnt;
    pulseStart();
    waitDone(d0, "t5_done", 1'b0, cyc);
    chk("t5_pops", popCnt - p0, 2);
    chk("t5_xfers", xferCnt - x0, 2);
    chk("t5_path_len", 32'(bus.path_len), 32'd2);
    chk("t5_ovf", 32'(bus.ovf), 32'd0);
    chk("t5_exp_left2", expq.size(), 0);

    // start pulsed again while emitting
    loadStack(4, 48'h0000_6362_6160);
    expPush(4, 48'h0000_6362_6160);
    bus.out_ready = 1'b0;
    d0 = doneCnt; p0 = popCnt; x0 = xferCnt;
    pulseStart();
    waitValid("t6_valid_seen");
    pulseStart();
    bus.out_ready = 1'b1;
    waitDone(d0, "t6_done", 1'b0, cyc);
    chk("t6_pops", popCnt - p0, 4);
    chk("t6_xfers", xferCnt - x0, 4);
    chk("t6_dones", doneCnt - d0, 1);
    chk("t6_path_len", 32'(bus.path_len), 32'd4);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_exp_left", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/path_dumper.md
PATH_DUMPER -- requirements
Module: path_dumper

Interface
REQ-001 Parameter LOC_W, default 8, width of one maze location word.
REQ-002 Parameter DEPTH, default 256, path buffer entries; max path length captured.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to drain the location stack and emit the path; sampled only in IDLE.
REQ-006 stk_loc  input  LOC_W  location word from the stack output; valid the cycle after a pop.
REQ-007 stk_empty  input  1  stack-empty flag from the stack.
REQ-008 stk_pop  output  1  pop request to the stack, registered, at most one cycle wide.
REQ-009 out_loc  output  LOC_W  path location being presented downstream.
REQ-010 out_valid  output  1  out_loc holds a valid path entry.
REQ-011 out_ready  input  1  downstream accepts out_loc when high with out_valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when path emission completes.
REQ-014 path_len  output  $clog2(DEPTH)+1  number of entries captured in the last drain; held until next start.
REQ-015 ovf  output  1  sticky until next start; stack still non-empty when buffer filled.

Function
REQ-016 FSM states SHALL be IDLE, POP, CAPT, EMIT, FIN.
REQ-017 IDLE: on start=1 with stk_empty=0 -> POP, clear cnt, path_len, ovf; with stk_empty=1 -> FIN, path_len=0.
REQ-018 POP: stk_pop=1 for exactly this cycle; -> CAPT unconditionally.
REQ-019 CAPT: write stk_loc into buf[cnt], cnt=cnt+1; stk_empty here reflects the post-pop stack.
REQ-020 CAPT exit: stk_empty=1 -> EMIT; cnt+1==DEPTH and stk_empty=0 -> set ovf, -> EMIT; else -> POP.
REQ-021 Drain cost SHALL be exactly 2 cycles per entry; stk_pop never asserted in two consecutive cycles.
REQ-022 On entry to EMIT, path_len=cnt and rd_idx=cnt-1.
REQ-023 Stack returns goal first; EMIT SHALL present entries from rd_idx down to 0, so start location comes out first and goal last.
REQ-024 EMIT: out_valid=1, out_loc=buf[rd_idx]; out_loc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Transfer on out_valid&out_ready; if rd_idx==0 -> FIN, else rd_idx=rd_idx-1, next entry next cycle.
REQ-026 With out_ready held high, one entry per cycle; no bubbles between entries.
REQ-027 FIN: done=1 for one cycle, out_valid=0; -> IDLE.
REQ-028 start while busy=1 SHALL be ignored, no effect on state or counters.
REQ-029 stk_pop SHALL never be asserted when stk_empty=1 was sampled at the decision point.
REQ-030 Empty-stack start: no stk_pop, no out_valid, done pulses 2 cycles after start.

Reset
REQ-031 rst=1 forces state IDLE immediately regardless of clk.
REQ-032 Reset values: stk_pop=0, out_valid=0, out_loc=0, busy=0, done=0, path_len=0, ovf=0, cnt=0, rd_idx=0.
REQ-033 Reset mid-drain or mid-emit SHALL abort with no further stk_pop or out_valid; buf contents need not be cleared.
REQ-034 First start after rst release SHALL be honoured on the first posedge.

Verification
REQ-035 Stack holds 0x00,0x01,0x11,0x12 (pushed in that order), out_ready=1, start -> stk_pop pulses 4 times 2 cycles apart; out_loc 0x00,0x01,0x11,0x12 on consecutive cycles; path_len=4; done once.
REQ-036 Same stack, out_ready toggling 1,0,0,1,... -> each out_loc held stable while stalled; order unchanged; no entry lost or duplicated.
REQ-037 Empty stack, start -> stk_pop never high, out_valid never high, path_len=0, done pulses exactly once.
REQ-038 DEPTH=4, stack holds 6 entries, start -> 4 pops, ovf=1, path_len=4; emits the 4 most recently pushed entries, oldest of them first.
REQ-039 rst asserted during EMIT after 2 of 4 transfers -> out_valid=0 and busy=0 immediately; new start drains the remaining stack contents.
REQ-040 start pulsed again during EMIT -> ignored; exactly path_len transfers and one done pulse.
